// File: rtl/csa_accum_pkg.sv
// Shared types and helpers for the carry-save accumulator controller.
// Holds the FSM state encoding and the resolve-chunk count helper.
package csa_accum_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int num_chunks(input int acc_w, input int chunk_w);
    return acc_w / chunk_w;
  endfunction

endpackage

// File: rtl/csa_bitlen.sv
// One row of full adders: compresses three BITLEN-bit words into sum and carry.
// Carry bit i has weight 2^(i+1); the caller is responsible for the shift.
module csa_bitlen #(
  parameter int BITLEN = 40
) (
  output logic [BITLEN-1:0] C,
  output logic [BITLEN-1:0] S,
  input  logic [BITLEN-1:0] X,
  input  logic [BITLEN-1:0] Y,
  input  logic [BITLEN-1:0] Z
);

  for (genvar gi = 0; gi < BITLEN; gi++) begin : g_fa
    assign S[gi] = X[gi] ^ Y[gi] ^ Z[gi];
    assign C[gi] = (X[gi] & Y[gi]) | (X[gi] & Z[gi]) | (Y[gi] & Z[gi]);
  end

endmodule

// File: rtl/csa_accum_ctrl.sv
// Packet accumulator: folds operands into a carry-save pair one per cycle, then
// resolves the pair with a CHUNK_W-bit ripple adder over ACC_W/CHUNK_W cycles.
module csa_accum_ctrl
  import csa_accum_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 40,
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count
);

  localparam int N_CHUNKS = num_chunks(ACC_W, CHUNK_W);
  localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  if (ACC_W % CHUNK_W != 0) begin : g_chunk_check
    $error("csa_accum_ctrl: ACC_W must be a multiple of CHUNK_W");
  end

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   s_reg, s_next;
  logic [ACC_W-1:0]   c_reg, c_next;
  logic [ACC_W-1:0]   res_reg, res_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               cin_reg, cin_next;

  logic [ACC_W-1:0]   z_ext;
  logic [ACC_W-1:0]   row_sum;
  logic [ACC_W-1:0]   row_carry;
  logic [CHUNK_W-1:0] s_chunk;
  logic [CHUNK_W-1:0] c_chunk;
  logic [CHUNK_W:0]   chunk_sum;

  assign z_ext = ACC_W'(in_data);

  csa_bitlen #(.BITLEN(ACC_W)) u_row (
    .C (row_carry),
    .S (row_sum),
    .X (s_reg),
    .Y (c_reg),
    .Z (z_ext)
  );

  assign s_chunk   = s_reg[int'(idx_reg) * CHUNK_W +: CHUNK_W];
  assign c_chunk   = c_reg[int'(idx_reg) * CHUNK_W +: CHUNK_W];
  assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + (CHUNK_W + 1)'(cin_reg);

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    c_next     = c_reg;
    res_next   = res_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    cin_next   = cin_reg;
    case (state_reg)
      ACCUM: begin
        if (in_valid) begin
          s_next = row_sum;
          // Shifting drops the top carry, which is exactly the mod 2^ACC_W wrap.
          c_next = row_carry << 1;
          if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
          if (in_last) begin
            state_next = RESOLVE;
            idx_next   = '0;
            cin_next   = 1'b0;
          end
        end
      end
      RESOLVE: begin
        res_next[int'(idx_reg) * CHUNK_W +: CHUNK_W] = chunk_sum[CHUNK_W-1:0];
        cin_next = chunk_sum[CHUNK_W];
        idx_next = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
          idx_next   = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          s_next     = '0;
          c_next     = '0;
          cnt_next   = '0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ACCUM;
      s_reg     <= '0;
      c_reg     <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      cin_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      c_reg     <= c_next;
      res_reg   <= res_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      cin_reg   <= cin_next;
    end
  end

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == DONE);
  assign out_data  = res_reg;
  assign out_count = cnt_reg;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: a vector table of uniform packets plus
// hand-written backpressure, mid-resolve reset and count-saturation sequences.
module tb_csa_accum_ctrl;

  localparam int N_CHUNKS = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [39:0] out_data;
  logic [15:0] out_count;

  logic        in_valid2, in_ready2, in_last2;
  logic [31:0] in_data2;
  logic        out_valid2, out_ready2;
  logic [39:0] out_data2;
  logic [3:0]  out_count2;

  int errors = 0;
  int checks = 0;
  int ready_bad = 0;

  always #5 clk = ~clk;

  csa_accum_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  csa_accum_ctrl #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data2),
    .in_last   (in_last2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .out_count (out_count2)
  );

  typedef struct {
    int          nbeats;
    logic [31:0] data;
    bit          gapped;
    logic [39:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input bit gap);
    if (!in_ready) ready_bad++;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (gap) step();
  endtask

  // Counts edges after the last-beat acceptance edge until out_valid is seen.
  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({name, "_valid_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_ready_after_hs"}, 64'(in_ready), 64'd1);
    check({name, "_valid_after_hs"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    logic [39:0] held;
    int bad;

    vecs[0] = '{1,   32'h0000_0005, 1'b0, 40'h00_0000_0005, 16'd1};
    vecs[1] = '{3,   32'hFFFF_FFFF, 1'b1, 40'h02_FFFF_FFFD, 16'd3};
    vecs[2] = '{257, 32'hFFFF_FFFF, 1'b0, 40'h00_FFFF_FEFF, 16'd257};
    vecs[3] = '{4,   32'h1234_5678, 1'b0, 40'h00_48D1_59E0, 16'd4};
    vecs[4] = '{2,   32'h8000_0000, 1'b1, 40'h01_0000_0000, 16'd2};

    rst_n = 1'b0;
    in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
    in_valid2 = 0; in_last2 = 0; in_data2 = '0; out_ready2 = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);

    for (int v = 0; v < 5; v++) begin
      ready_bad = 0;
      for (int b = 0; b < vecs[v].nbeats; b++)
        send_beat(vecs[v].data, b == vecs[v].nbeats - 1, vecs[v].gapped && (b != vecs[v].nbeats - 1));
      wait_valid($sformatf("vec%0d", v), lat);
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'(N_CHUNKS));
      check($sformatf("vec%0d_in_ready_accum", v), 64'(ready_bad), 64'd0);
      check($sformatf("vec%0d_data", v), 64'(out_data), 64'(vecs[v].exp_data));
      check($sformatf("vec%0d_count", v), 64'(out_count), 64'(vecs[v].exp_cnt));
      $display("vec%0d: beats=%0d data=%0h -> out_data=%0h out_count=%0d", v,
               vecs[v].nbeats, vecs[v].data, out_data, out_count);
      handshake($sformatf("vec%0d", v));
    end

    // Backpressure: result must hold while out_ready stays low.
    send_beat(32'h0000_0010, 1'b1, 1'b0);
    wait_valid("bp", lat);
    held = out_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      step();
    end
    check("bp_held_data", 64'(held), 64'h10);
    check("bp_stable", 64'(bad), 64'd0);
    handshake("bp");
    send_beat(32'h0000_0007, 1'b1, 1'b0);
    wait_valid("bp_next", lat);
    check("bp_next_data", 64'(out_data), 64'h7);
    check("bp_next_count", 64'(out_count), 64'd1);
    $display("backpressure: held=%0h next=%0h", held, out_data);
    handshake("bp_next");

    // Reset while resolving: the partial result must never surface.
    send_beat(32'h0000_00FF, 1'b0, 1'b0);
    send_beat(32'h0000_00FF, 1'b1, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_in_ready",  64'(in_ready),  64'd1);
    check("rstmid_count",     64'(out_count), 64'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) bad++;
      step();
    end
    check("rstmid_no_valid", 64'(bad), 64'd0);
    send_beat(32'd1, 1'b0, 1'b0);
    send_beat(32'd2, 1'b1, 1'b0);
    wait_valid("rstmid_next", lat);
    check("rstmid_next_data", 64'(out_data), 64'd3);
    check("rstmid_next_count", 64'(out_count), 64'd2);
    $display("reset mid-resolve: next packet out_data=%0h out_count=%0d", out_data, out_count);
    handshake("rstmid_next");

    // Count saturation on the CNT_W=4 instance.
    for (int b = 0; b < 20; b++) begin
      in_valid2 = 1'b1;
      in_data2  = 32'd1;
      in_last2  = (b == 19);
      step();
    end
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 40) begin
      step();
      lat++;
    end
    check("sat_valid_timeout", 64'(out_valid2), 64'd1);
    check("sat_data",  64'(out_data2),  64'd20);
    check("sat_count", 64'(out_count2), 64'd15);
    $display("saturation: out_data=%0d out_count=%0d", out_data2, out_count2);
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
    check("sat_ready_after_hs", 64'(in_ready2), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
